// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar scheduler: FSM state codes, timer width
// and the helper that builds the all-ones timeout marker for a counter width.
package sonar_pkg;

  typedef logic [2:0] sonar_state_t;

  localparam sonar_state_t IDLE      = 3'd0;
  localparam sonar_state_t TRIG      = 3'd1;
  localparam sonar_state_t WAIT_RISE = 3'd2;
  localparam sonar_state_t MEASURE   = 3'd3;
  localparam sonar_state_t GUARD     = 3'd4;

  // One shared timer covers trigger, timeout and guard intervals.
  localparam int TIMER_W = 32;

  // All-ones code of the given width; a real echo width never reaches it
  // because the width counter saturates one below.
  function automatic logic [63:0] timeout_code(input int unsigned cnt_w);
    logic [63:0] code;
    code = 64'd0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < cnt_w) begin
        code[i] = 1'b1;
      end else begin
        code[i] = 1'b0;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Brings one raw echo pin into the clk domain and produces single-cycle
// rise/fall pulses. Pin-to-pulse latency is two clocks.
module sonar_echo_sync
  import sonar_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Two-stage synchronizer followed by a history stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= echo;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/measure sequencer shared across N ultrasonic sonars.
// Only one channel is active at a time so echoes never overlap; each channel
// gets a trigger pulse, an echo-width measurement with timeout, and a guard
// gap before the next channel. One result per channel is held for readout.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter  int N_SONAR        = 4,
  parameter  int CNT_W          = 32,
  parameter  int TRIG_CYCLES    = 500,
  parameter  int TIMEOUT_CYCLES = 3_000_000,
  parameter  int GUARD_CYCLES   = 50_000,
  localparam int CH_W           = (N_SONAR > 1) ? $clog2(N_SONAR) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_SONAR-1:0]       chan_mask,
  input  logic [N_SONAR-1:0]       echo,
  output logic [N_SONAR-1:0]       trigger,
  output logic [N_SONAR*CNT_W-1:0] count_flat,
  output logic [N_SONAR-1:0]       timeout,
  output logic                     done,
  output logic [CH_W-1:0]          done_chan
);

  localparam logic [CNT_W-1:0]   TIMEOUT_CODE = CNT_W'(timeout_code(CNT_W));
  localparam logic [CNT_W-1:0]   WIDTH_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   WIDTH_MAX    = TIMEOUT_CODE - WIDTH_ONE;
  localparam logic [TIMER_W-1:0] TIMER_ZERO   = TIMER_W'(1'b0);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1'b1);
  localparam logic [TIMER_W-1:0] TRIG_LAST    = TIMER_W'(TRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST     = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GUARD_LAST   = TIMER_W'(GUARD_CYCLES - 1);
  localparam logic [N_SONAR-1:0] ONE_HOT0     = N_SONAR'(1'b1);
  localparam logic [CH_W-1:0]    LAST_CHAN    = CH_W'(N_SONAR - 1);

  sonar_state_t       state_r;
  logic [CH_W-1:0]    cur_r;
  logic [TIMER_W-1:0] timer_r;
  logic [CNT_W-1:0]   width_r;
  logic [N_SONAR-1:0] trigger_r;
  logic [CNT_W-1:0]   count_r [N_SONAR];
  logic [N_SONAR-1:0] timeout_r;
  logic               done_r;
  logic [CH_W-1:0]    done_chan_r;

  logic [N_SONAR-1:0] echo_level_s;
  logic [N_SONAR-1:0] echo_rise_s;
  logic [N_SONAR-1:0] echo_fall_s;
  logic               cur_level_s;
  logic               cur_rise_s;
  logic               start_s;
  logic               echo_end_s;
  logic               tmo_hit_s;
  logic [CH_W-1:0]    next_chan_s;

  // First mask bit strictly after cur, wrapping; a lone bit reselects cur.
  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0]    cur,
                                               input logic [N_SONAR-1:0] mask);
    logic [CH_W-1:0] res;
    logic            hit;
    int              idx;
    res = cur;
    hit = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_SONAR; k++) begin
      idx = (int'(cur) + k) % N_SONAR;
      if (!hit && mask[idx]) begin
        res = idx[CH_W-1:0];
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < N_SONAR; g++) begin : g_chan
    sonar_echo_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .echo  (echo[g]),
      .level (echo_level_s[g]),
      .rise  (echo_rise_s[g]),
      .fall  (echo_fall_s[g])
    );
    assign count_flat[g*CNT_W +: CNT_W] = count_r[g];
  end

  assign cur_level_s = echo_level_s[cur_r];
  assign cur_rise_s  = echo_rise_s[cur_r];
  assign start_s     = enable & (|chan_mask);
  assign next_chan_s = rr_next(cur_r, chan_mask);
  // A falling edge only ends a measurement that actually started; it takes
  // priority over a timeout landing in the same cycle.
  assign echo_end_s  = (state_r == MEASURE) & echo_fall_s[cur_r];
  assign tmo_hit_s   = (timer_r == TMO_LAST);

  assign trigger   = trigger_r;
  assign timeout   = timeout_r;
  assign done      = done_r;
  assign done_chan = done_chan_r;

  // Scheduler FSM with the shared timer, width counter and result latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cur_r       <= LAST_CHAN;
      timer_r     <= TIMER_ZERO;
      width_r     <= '0;
      trigger_r   <= '0;
      timeout_r   <= '0;
      done_r      <= 1'b0;
      done_chan_r <= '0;
      for (int i = 0; i < N_SONAR; i++) begin
        count_r[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cur_r     <= next_chan_s;
            trigger_r <= ONE_HOT0 << next_chan_s;
            timer_r   <= TIMER_ZERO;
            state_r   <= TRIG;
          end else begin
            trigger_r <= '0;
          end
        end
        TRIG: begin
          if (timer_r == TRIG_LAST) begin
            trigger_r <= '0;
            timer_r   <= TIMER_ZERO;
            state_r   <= WAIT_RISE;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        WAIT_RISE, MEASURE: begin
          if (echo_end_s) begin
            count_r[cur_r]   <= width_r;
            timeout_r[cur_r] <= 1'b0;
            done_r           <= 1'b1;
            done_chan_r      <= cur_r;
            timer_r          <= TIMER_ZERO;
            state_r          <= GUARD;
          end else if (tmo_hit_s) begin
            count_r[cur_r]   <= TIMEOUT_CODE;
            timeout_r[cur_r] <= 1'b1;
            done_r           <= 1'b1;
            done_chan_r      <= cur_r;
            timer_r          <= TIMER_ZERO;
            state_r          <= GUARD;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
            if (state_r == WAIT_RISE) begin
              // A level already high on entry produces no rise pulse, so it
              // is ignored until it drops and rises again.
              if (cur_rise_s) begin
                width_r <= WIDTH_ONE;
                state_r <= MEASURE;
              end else begin
                width_r <= width_r;
              end
            end else if (cur_level_s && (width_r != WIDTH_MAX)) begin
              width_r <= width_r + WIDTH_ONE;
            end else begin
              width_r <= width_r;
            end
          end
        end
        GUARD: begin
          if (timer_r == GUARD_LAST) begin
            timer_r <= TIMER_ZERO;
            if (start_s) begin
              cur_r     <= next_chan_s;
              trigger_r <= ONE_HOT0 << next_chan_s;
              state_r   <= TRIG;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          trigger_r <= '0;
          timer_r   <= TIMER_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: a directed table, hand-written
// corner sequences and a randomized run, all checked against a transaction
// level model of the schedule (RR order, latency formula, result rules).
module tb_sonar_scheduler;

  localparam int N    = 4;
  localparam int CW   = 32;
  localparam int TRIG = 5;
  localparam int TO   = 100;
  localparam int GRD  = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [3:0]   chan_mask = 4'h0;
  logic [3:0]   echo = 4'h0;
  logic [3:0]   trigger;
  logic [127:0] count_flat;
  logic [3:0]   timeout;
  logic         done;
  logic [1:0]   done_chan;

  int           checks = 0;
  int           failures = 0;
  int           mdl_cur;
  logic [31:0]  mdl_cnt [4];
  logic [3:0]   mdl_to;
  int           last_ch;

  typedef struct {
    bit          rst;
    logic [3:0]  mask;
    int          d;
    int          w;
    bit          has_echo;
    int          exp_ch;
    logic [31:0] exp_cnt;
    bit          exp_to;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  sonar_scheduler #(
    .N_SONAR        (N),
    .CNT_W          (CW),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TO),
    .GUARD_CYCLES   (GRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .chan_mask  (chan_mask),
    .echo       (echo),
    .trigger    (trigger),
    .count_flat (count_flat),
    .timeout    (timeout),
    .done       (done),
    .done_chan  (done_chan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int cur, input logic [3:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(cur + k) % N]) return (cur + k) % N;
    end
    return cur;
  endfunction

  function automatic logic [3:0] onehot(input int ch);
    logic [3:0] v;
    v = 4'b0001 << ch;
    return v;
  endfunction

  function automatic logic [127:0] mdl_flat();
    logic [127:0] v;
    v = 128'd0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = mdl_cnt[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mdl_cnt[i] = 32'd0;
    mdl_to  = 4'h0;
    mdl_cur = N - 1;
  endtask

  // Holds reset, checks reset values, releases; returns at the cycle the
  // first trigger is expected.
  task automatic do_reset(input logic [3:0] m, input logic en);
    reset = 1'b1;
    chan_mask = m;
    enable = en;
    repeat (3) step();
    check("rst_trigger", 128'(trigger), 128'd0);
    check("rst_count", count_flat, 128'd0);
    check("rst_timeout", 128'(timeout), 128'd0);
    check("rst_done", 128'({done, done_chan}), 128'd0);
    model_clear();
    reset = 1'b0;
    step();
  endtask

  // Called at the cycle a trigger should start; returns at the done cycle.
  task automatic run_channel(input int d, input int w, input bit has_echo,
                             input int pre_until, input int drop_at);
    int ch;
    int lat;
    bit ok;
    bit tmo;
    ch = rr_pick(mdl_cur, chan_mask);
    mdl_cur = ch;
    last_ch = ch;
    check("trig_start", 128'(trigger), 128'(onehot(ch)));
    ok = 1'b1;
    for (int i = 1; i < TRIG; i++) begin
      step();
      if (trigger !== onehot(ch) || done !== 1'b0) ok = 1'b0;
    end
    check("trig_width", 128'(ok), 128'd1);
    step();
    check("trig_fall", 128'(trigger), 128'd0);
    tmo = !(has_echo && (d + w + 3 <= TO));
    lat = tmo ? TO : d + w + 3;
    ok = 1'b1;
    for (int k = 0; k < lat; k++) begin
      echo[ch] = (k < pre_until) || (has_echo && k >= d && k < d + w);
      if (k == drop_at) enable = 1'b0;
      if (done !== 1'b0 || trigger !== 4'h0) ok = 1'b0;
      step();
    end
    echo[ch] = 1'b0;
    check("quiet_before_done", 128'(ok), 128'd1);
    if (tmo) begin
      mdl_cnt[ch] = 32'hFFFF_FFFF;
      mdl_to[ch]  = 1'b1;
    end else begin
      mdl_cnt[ch] = 32'(w);
      mdl_to[ch]  = 1'b0;
    end
    check("done_pulse", 128'(done), 128'd1);
    check("done_chan", 128'(done_chan), 128'(ch));
    check("count_flat", count_flat, mdl_flat());
    check("timeout_vec", 128'(timeout), 128'(mdl_to));
  endtask

  // Walks the guard gap from the done cycle to the next trigger slot.
  task automatic guard_wait();
    bit ok;
    ok = 1'b1;
    for (int i = 1; i <= GRD; i++) begin
      step();
      if (i < GRD && (trigger !== 4'h0 || done !== 1'b0)) ok = 1'b0;
    end
    check("guard_quiet", 128'(ok), 128'd1);
  endtask

  // Stimulus sequence: table, corner cases, random phase, summary
  initial begin
    int d;
    int w;
    bit he;
    bit ok;
    tbl[0] = '{1'b1, 4'hF, 3, 20, 1'b1, 0, 32'd20, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 0, 5, 1'b1, 1, 32'd5, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 10, 87, 1'b1, 2, 32'd87, 1'b0};
    tbl[3] = '{1'b0, 4'hF, 10, 88, 1'b1, 3, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{1'b1, 4'hA, 1, 7, 1'b1, 1, 32'd7, 1'b0};
    tbl[5] = '{1'b0, 4'hA, 4, 40, 1'b1, 3, 32'd40, 1'b0};
    tbl[6] = '{1'b0, 4'hA, 2, 7, 1'b1, 1, 32'd7, 1'b0};
    tbl[7] = '{1'b1, 4'h4, 0, 0, 1'b0, 2, 32'hFFFF_FFFF, 1'b1};
    tbl[8] = '{1'b0, 4'h4, 5, 12, 1'b1, 2, 32'd12, 1'b0};
    model_clear();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) begin
        do_reset(tbl[i].mask, 1'b1);
      end else begin
        chan_mask = tbl[i].mask;
        guard_wait();
      end
      run_channel(tbl[i].d, tbl[i].w, tbl[i].has_echo, 0, -1);
      check("tbl_chan", 128'(last_ch), 128'(tbl[i].exp_ch));
      check("tbl_count", 128'(count_flat[tbl[i].exp_ch*CW +: CW]), 128'(tbl[i].exp_cnt));
      check("tbl_timeout", 128'(timeout[tbl[i].exp_ch]), 128'(tbl[i].exp_to));
    end

    // Echo already high before the trigger: only the later pulse counts
    echo[0] = 1'b1;
    do_reset(4'hF, 1'b1);
    run_channel(9, 15, 1'b1, 6, -1);
    check("prehigh_count0", 128'(count_flat[0 +: CW]), 128'd15);

    // Enable dropped mid-measurement: channel finishes, then no trigger
    guard_wait();
    run_channel(2, 20, 1'b1, 0, 10);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (trigger !== 4'h0 || done !== 1'b0) ok = 1'b0;
    end
    check("idle_after_disable", 128'(ok), 128'd1);
    enable = 1'b1;
    step();
    run_channel(1, 4, 1'b1, 0, -1);

    // Asynchronous reset in the middle of a trigger pulse
    guard_wait();
    check("pre_reset_trig", 128'(trigger), 128'(onehot(rr_pick(mdl_cur, chan_mask))));
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_trig", 128'(trigger), 128'd0);
    check("async_count", count_flat, 128'd0);
    check("async_timeout", 128'(timeout), 128'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    run_channel(2, 9, 1'b1, 0, -1);
    check("restart_ch0", 128'(last_ch), 128'd0);

    // Randomized channels with changing masks
    for (int r = 0; r < 25; r++) begin
      chan_mask = 4'($urandom_range(1, 15));
      guard_wait();
      d  = $urandom_range(0, 20);
      w  = $urandom_range(1, 60);
      he = ($urandom_range(0, 4) != 0);
      run_channel(d, w, he, 0, -1);
    end
    step();
    check("done_single", 128'(done), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
